// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
// Serialises register-file accesses from the I2C slave front end and the
// internal protocol FSMs onto one Registers port. Grants alternate when both
// requesters are waiting, and every access is bounded by an ACK timeout.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no transaction; arbitrate and latch the winner's request
// S_ISSUE   | one-cycle reg_req strobe; timeout counter cleared
// S_WAIT    | waiting for reg_ack or for the timeout to expire
// S_RELEASE | transaction done; wait for the owner to drop its req
module reg_access_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              i2c_req,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic              i2c_rnw,
    input  logic [DATA_W-1:0] i2c_wr_data,
    output logic              i2c_ack,
    output logic              i2c_err,
    output logic [DATA_W-1:0] i2c_rd_data,
    input  logic              fsm_req,
    input  logic [ADDR_W-1:0] fsm_addr,
    input  logic              fsm_rnw,
    input  logic [DATA_W-1:0] fsm_wr_data,
    output logic              fsm_ack,
    output logic              fsm_err,
    output logic [DATA_W-1:0] fsm_rd_data,
    output logic              reg_req,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rnw,
    output logic [DATA_W-1:0] reg_wr_data,
    input  logic [DATA_W-1:0] reg_rd_data,
    input  logic              reg_ack,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    // Counter value in the last WAIT cycle that may still accept reg_ack.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rnw_q, rnw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              i2c_ack_q, i2c_ack_d, i2c_err_q, i2c_err_d;
    logic              fsm_ack_q, fsm_ack_d, fsm_err_q, fsm_err_d;
    logic [DATA_W-1:0] i2c_rd_q, i2c_rd_d, fsm_rd_q, fsm_rd_d;
    logic              grant_fsm, timed_out, done;
    logic [DATA_W-1:0] rd_val;

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            rnw_q        <= 1'b0;
            wdata_q      <= '0;
            i2c_ack_q    <= 1'b0;
            i2c_err_q    <= 1'b0;
            i2c_rd_q     <= '0;
            fsm_ack_q    <= 1'b0;
            fsm_err_q    <= 1'b0;
            fsm_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rnw_q        <= rnw_d;
            wdata_q      <= wdata_d;
            i2c_ack_q    <= i2c_ack_d;
            i2c_err_q    <= i2c_err_d;
            i2c_rd_q     <= i2c_rd_d;
            fsm_ack_q    <= fsm_ack_d;
            fsm_err_q    <= fsm_err_d;
            fsm_rd_q     <= fsm_rd_d;
        end
    end

    // Arbitration, timeout and completion logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rnw_d        = rnw_q;
        wdata_d      = wdata_q;
        i2c_ack_d    = 1'b0;
        i2c_err_d    = 1'b0;
        i2c_rd_d     = i2c_rd_q;
        fsm_ack_d    = 1'b0;
        fsm_err_d    = 1'b0;
        fsm_rd_d     = fsm_rd_q;
        grant_fsm    = 1'b0;
        timed_out    = 1'b0;
        done         = 1'b0;
        rd_val       = '0;
        case (state_q)
            S_IDLE: begin
                if (i2c_req || fsm_req) begin
                    // On a tie the requester that was not served last wins.
                    grant_fsm = fsm_req && (!i2c_req || !last_owner_q);
                    owner_d   = grant_fsm;
                    addr_d    = grant_fsm ? fsm_addr    : i2c_addr;
                    rnw_d     = grant_fsm ? fsm_rnw     : i2c_rnw;
                    wdata_d   = grant_fsm ? fsm_wr_data : i2c_wr_data;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d     = cnt_q + 8'd1;
                // A reg_ack arriving on the last allowed cycle still counts as success.
                timed_out = !reg_ack && (cnt_q == TO_LAST);
                done      = reg_ack || timed_out;
                rd_val    = timed_out ? '0 : reg_rd_data;
                if (done) begin
                    if (owner_q) begin
                        fsm_ack_d = 1'b1;
                        fsm_err_d = timed_out;
                        if (rnw_q) fsm_rd_d = rd_val;
                    end else begin
                        i2c_ack_d = 1'b1;
                        i2c_err_d = timed_out;
                        if (rnw_q) i2c_rd_d = rd_val;
                    end
                    last_owner_d = owner_q;
                    state_d      = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (owner_q ? !fsm_req : !i2c_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign reg_req     = (state_q == S_ISSUE);
    assign reg_addr    = addr_q;
    assign reg_rnw     = rnw_q;
    assign reg_wr_data = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign i2c_ack     = i2c_ack_q;
    assign i2c_err     = i2c_err_q;
    assign i2c_rd_data = i2c_rd_q;
    assign fsm_ack     = fsm_ack_q;
    assign fsm_err     = fsm_err_q;
    assign fsm_rd_data = fsm_rd_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed transactions, a Registers responder
// with programmable latency, and queue-based monitors for reg_req and acks.
module tb_reg_access_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          i2c_req = 1'b0, i2c_rnw = 1'b0;
    logic [AW-1:0] i2c_addr = '0;
    logic [DW-1:0] i2c_wr_data = '0;
    logic          i2c_ack, i2c_err;
    logic [DW-1:0] i2c_rd_data;
    logic          fsm_req = 1'b0, fsm_rnw = 1'b0;
    logic [AW-1:0] fsm_addr = '0;
    logic [DW-1:0] fsm_wr_data = '0;
    logic          fsm_ack, fsm_err;
    logic [DW-1:0] fsm_rd_data;
    logic          reg_req, reg_rnw;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data;
    logic [DW-1:0] reg_rd_data = '0;
    logic          reg_ack = 1'b0;
    logic          busy, owner;

    reg_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .reset(reset),
        .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_rnw(i2c_rnw), .i2c_wr_data(i2c_wr_data),
        .i2c_ack(i2c_ack), .i2c_err(i2c_err), .i2c_rd_data(i2c_rd_data),
        .fsm_req(fsm_req), .fsm_addr(fsm_addr), .fsm_rnw(fsm_rnw), .fsm_wr_data(fsm_wr_data),
        .fsm_ack(fsm_ack), .fsm_err(fsm_err), .fsm_rd_data(fsm_rd_data),
        .reg_req(reg_req), .reg_addr(reg_addr), .reg_rnw(reg_rnw), .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data), .reg_ack(reg_ack),
        .busy(busy), .owner(owner)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          port;
        logic          err;
        logic [DW-1:0] rd;
        logic [DW-1:0] ord;
        int            lat;
    } ack_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rnw;
        logic [DW-1:0] wd;
    } reg_exp_t;

    ack_exp_t      ack_q[$];
    reg_exp_t      reg_q[$];
    logic [DW-1:0] mrd[2];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last_req_cyc = 0;
    int            resp_lat = 0;
    logic [DW-1:0] resp_data = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {i2c_ack, i2c_err, i2c_rd_data, fsm_ack, fsm_err, fsm_rd_data,
                reg_req, reg_addr, reg_rnw, reg_wr_data, busy, owner};
    endfunction

    // Expected result of one transaction; resp == 0 means Registers never answers.
    task automatic push_txn(input logic port, input logic [AW-1:0] addr, input logic rnw,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rdata, input int resp);
        ack_exp_t a;
        reg_exp_t r;
        r.addr = addr; r.rnw = rnw; r.wd = wd;
        reg_q.push_back(r);
        a.port = port;
        a.err  = (resp == 0);
        if (rnw) mrd[port] = (resp == 0) ? '0 : rdata;
        a.rd   = mrd[port];
        a.ord  = mrd[~port];
        a.lat  = (resp == 0) ? TO + 1 : resp + 1;
        ack_q.push_back(a);
    endtask

    task automatic raise(input logic port, input logic [AW-1:0] addr, input logic rnw,
                         input logic [DW-1:0] wd);
        if (port) begin
            fsm_req = 1'b1; fsm_addr = addr; fsm_rnw = rnw; fsm_wr_data = wd;
        end else begin
            i2c_req = 1'b1; i2c_addr = addr; i2c_rnw = rnw; i2c_wr_data = wd;
        end
    endtask

    task automatic wait_ack(input logic port);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (port ? fsm_ack : i2c_ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL ack_wait port=%0d: got no ack within 100 cycles, expected one", port);
        end
    endtask

    task automatic txn(input logic port, input logic [AW-1:0] addr, input logic rnw,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rdata, input int resp);
        push_txn(port, addr, rnw, wd, rdata, resp);
        resp_lat = resp; resp_data = rdata;
        @(posedge CLK); #1;
        raise(port, addr, rnw, wd);
        wait_ack(port);
        @(posedge CLK); #1;
        if (port) fsm_req = 1'b0; else i2c_req = 1'b0;
        @(posedge CLK); #1;
        chk("idle_after_release", 64'(busy), 64'd0);
    endtask

    // Registers model: answers reg_req after resp_lat cycles, or never when 0.
    initial forever begin
        @(negedge CLK);
        if (reset && reg_req && resp_lat > 0) begin
            repeat (resp_lat) @(negedge CLK);
            reg_rd_data = resp_data;
            reg_ack = 1'b1;
            @(negedge CLK);
            reg_ack = 1'b0;
            reg_rd_data = '0;
        end
    end

    // Register-side monitor.
    always @(negedge CLK) begin
        if (reset && reg_req) begin
            last_req_cyc = cyc;
            if (reg_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_reg_req: got request addr 0x%0h, expected none", reg_addr);
            end else begin
                reg_exp_t e;
                e = reg_q.pop_front();
                chk("reg_addr", 64'(reg_addr), 64'(e.addr));
                chk("reg_rnw", 64'(reg_rnw), 64'(e.rnw));
                chk("reg_wr_data", 64'(reg_wr_data), 64'(e.wd));
            end
        end
    end

    // Requester-side monitor.
    always @(negedge CLK) begin
        if (reset && (i2c_ack || fsm_ack)) begin
            if (i2c_ack && fsm_ack) begin
                total++; bad++;
                $display("FAIL double_ack: got both acks high, expected one");
            end else if (ack_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: got i2c_ack=%0d fsm_ack=%0d, expected none", i2c_ack, fsm_ack);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                chk("ack_port", 64'(fsm_ack), 64'(e.port));
                chk("ack_err", 64'(e.port ? fsm_err : i2c_err), 64'(e.err));
                chk("owner_rd_data", 64'(e.port ? fsm_rd_data : i2c_rd_data), 64'(e.rd));
                chk("other_rd_data", 64'(e.port ? i2c_rd_data : fsm_rd_data), 64'(e.ord));
                chk("owner", 64'(owner), 64'(e.port));
                chk("ack_latency", 64'(cyc - last_req_cyc), 64'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        bit seen;
        mrd[0] = '0; mrd[1] = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("idle_after_reset", all_outs(), 64'd0);

        // Single I2C write and single FSM read.
        txn(1'b0, 8'h10, 1'b0, 16'hA5A5, 16'h0000, 2);
        txn(1'b1, 8'h12, 1'b1, 16'h0000, 16'h00FF, 1);

        // Fairness: fresh reset, both requesting together.
        @(negedge CLK); reset = 1'b0; mrd[0] = '0; mrd[1] = '0;
        @(negedge CLK); reset = 1'b1;
        push_txn(1'b0, 8'h20, 1'b0, 16'h1111, 16'h0000, 1);
        push_txn(1'b1, 8'h21, 1'b1, 16'h0000, 16'hBEEF, 1);
        push_txn(1'b0, 8'h22, 1'b1, 16'h0000, 16'h5555, 1);
        push_txn(1'b1, 8'h21, 1'b1, 16'h0000, 16'h5555, 1);
        resp_lat = 1; resp_data = 16'hBEEF;
        @(posedge CLK); #1;
        raise(1'b0, 8'h20, 1'b0, 16'h1111);
        raise(1'b1, 8'h21, 1'b1, 16'h0000);
        wait_ack(1'b0);
        @(posedge CLK); #1; i2c_req = 1'b0;
        wait_ack(1'b1);
        resp_data = 16'h5555;
        @(posedge CLK); #1; fsm_req = 1'b0;
        @(posedge CLK); #1;
        raise(1'b0, 8'h22, 1'b1, 16'h0000);
        fsm_req = 1'b1;
        wait_ack(1'b0);
        @(posedge CLK); #1; i2c_req = 1'b0;
        wait_ack(1'b1);
        @(posedge CLK); #1; fsm_req = 1'b0;
        @(posedge CLK); #1;
        chk("idle_after_fairness", 64'(busy), 64'd0);

        // Timeout on an FSM read.
        txn(1'b1, 8'h30, 1'b1, 16'h0000, 16'hDEAD, 0);

        // Reset in the middle of WAIT, then a late reg_ack.
        begin
            reg_exp_t r;
            r.addr = 8'h40; r.rnw = 1'b0; r.wd = 16'h7777;
            reg_q.push_back(r);
        end
        resp_lat = 0;
        @(posedge CLK); #1;
        raise(1'b0, 8'h40, 1'b0, 16'h7777);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (reg_req) begin seen = 1'b1; break; end
        end
        chk("reg_req_before_reset", 64'(seen), 64'd1);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("mid_wait_reset_outputs", all_outs(), 64'd0);
        i2c_req = 1'b0;
        mrd[0] = '0; mrd[1] = '0;
        @(negedge CLK); reset = 1'b1; reg_ack = 1'b1; reg_rd_data = 16'h9999;
        @(negedge CLK); reg_ack = 1'b0; reg_rd_data = '0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i2c_ack || fsm_ack) acks++;
        end
        chk("late_ack_ignored", 64'(acks), 64'd0);
        chk("busy_after_late_ack", 64'(busy), 64'd0);
        txn(1'b0, 8'h41, 1'b1, 16'h0000, 16'h1234, 1);

        // Held request must not be re-granted until it drops.
        push_txn(1'b0, 8'h42, 1'b0, 16'h0F0F, 16'h0000, 1);
        resp_lat = 1;
        @(posedge CLK); #1;
        raise(1'b0, 8'h42, 1'b0, 16'h0F0F);
        wait_ack(1'b0);
        repeat (6) @(posedge CLK);
        #1;
        chk("busy_while_req_held", 64'(busy), 64'd1);
        i2c_req = 1'b0;
        @(posedge CLK); #1;
        chk("idle_after_held_drop", 64'(busy), 64'd0);
        txn(1'b0, 8'h42, 1'b1, 16'h0000, 16'hCAFE, 2);

        repeat (3) @(negedge CLK);
        chk("reg_queue_empty", 64'(reg_q.size()), 64'd0);
        chk("ack_queue_empty", 64'(ack_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
